// File: rtl/n_operand_multiplier.sv
// Sequential shift-add multiplier for NUM_OPS unsigned operands with a valid/done/ack handshake.
// Optional build macro ZERO_SKIP_EN: short-circuits any request containing a zero operand.
module n_operand_multiplier #(
    parameter int WIDTH     = 16,
    parameter int NUM_OPS   = 4,
    parameter int CNT_WIDTH = 5
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [NUM_OPS*WIDTH-1:0]   iData,
    input  logic                       iValid_Data,
    input  logic                       iAcknoledged,
    output logic                       oDone,
    output logic                       oIdle,
    output logic [NUM_OPS*WIDTH-1:0]   oResult
);

    localparam int RW = NUM_OPS * WIDTH;
    localparam int KW = $clog2(NUM_OPS);
    localparam logic [KW-1:0]        K_LAST   = KW'(NUM_OPS - 1);
    localparam logic [CNT_WIDTH-1:0] BIT_LAST = CNT_WIDTH'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                state, state_d;
    logic [RW-1:0]         op_q;
    logic [RW-1:0]         mcand;
    logic [WIDTH-1:0]      mplier;
    logic [RW-1:0]         prod;
    logic [KW-1:0]         k;
    logic [KW-1:0]         k_inc;
    logic [CNT_WIDTH-1:0]  bitcnt;
    logic [WIDTH-1:0]      next_op;
    logic                  any_zero;

`ifdef ZERO_SKIP_EN
    always_comb begin
        any_zero = 1'b0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (iData[i*WIDTH +: WIDTH] == '0) any_zero = 1'b1;
        end
    end
`else
    assign any_zero = 1'b0;
`endif

    // Wrap instead of running past the last lane; the wrapped value is never consumed.
    assign k_inc = (k == K_LAST) ? '0 : k + KW'(1);

    always_comb begin
        next_op = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (k_inc == KW'(i)) next_op = op_q[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= S_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: if (iValid_Data) state_d = any_zero ? S_NEXT : S_MUL;
            S_MUL:  if (bitcnt == BIT_LAST) state_d = S_NEXT;
            S_NEXT: state_d = (k == K_LAST) ? S_DONE : S_MUL;
            S_DONE: if (iAcknoledged) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            op_q    <= '0;
            mcand   <= '0;
            mplier  <= '0;
            prod    <= '0;
            k       <= '0;
            bitcnt  <= '0;
            oResult <= '0;
            oDone   <= 1'b0;
            oIdle   <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (iValid_Data) begin
                        op_q   <= iData;
                        mcand  <= {{(RW-WIDTH){1'b0}}, iData[WIDTH-1:0]};
                        mplier <= iData[2*WIDTH-1:WIDTH];
                        prod   <= '0;
                        // A zero lane jumps straight to the final NEXT step with prod already 0.
                        k      <= any_zero ? K_LAST : KW'(1);
                        bitcnt <= '0;
                        oIdle  <= 1'b0;
                    end
                end
                S_MUL: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    bitcnt <= bitcnt + CNT_WIDTH'(1);
                end
                S_NEXT: begin
                    if (k == K_LAST) begin
                        oResult <= prod;
                        oDone   <= 1'b1;
                    end else begin
                        mcand  <= prod;
                        mplier <= next_op;
                        prod   <= '0;
                        k      <= k_inc;
                        bitcnt <= '0;
                    end
                end
                S_DONE: begin
                    if (iAcknoledged) begin
                        oDone <= 1'b0;
                        oIdle <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_n_operand_multiplier.sv
// Directed bench for n_operand_multiplier: default build plus two parameter variants.
module tb_n_operand_multiplier;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;

    logic [63:0] data_a = '0;
    logic        valid_a = 1'b0, ack_a = 1'b0;
    logic        done_a, idle_a;
    logic [63:0] res_a;

    logic [15:0] data_b = '0;
    logic        valid_b = 1'b0, ack_b = 1'b0;
    logic        done_b, idle_b;
    logic [15:0] res_b;

    logic [31:0] data_c = '0;
    logic        valid_c = 1'b0, ack_c = 1'b0;
    logic        done_c, idle_c;
    logic [31:0] res_c;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    n_operand_multiplier #(.WIDTH(16), .NUM_OPS(4), .CNT_WIDTH(5)) dut (
        .Clock(Clock), .Reset(Reset), .iData(data_a), .iValid_Data(valid_a),
        .iAcknoledged(ack_a), .oDone(done_a), .oIdle(idle_a), .oResult(res_a)
    );

    n_operand_multiplier #(.WIDTH(8), .NUM_OPS(2), .CNT_WIDTH(4)) dut_b (
        .Clock(Clock), .Reset(Reset), .iData(data_b), .iValid_Data(valid_b),
        .iAcknoledged(ack_b), .oDone(done_b), .oIdle(idle_b), .oResult(res_b)
    );

    n_operand_multiplier #(.WIDTH(4), .NUM_OPS(8), .CNT_WIDTH(3)) dut_c (
        .Clock(Clock), .Reset(Reset), .iData(data_c), .iValid_Data(valid_c),
        .iAcknoledged(ack_c), .oDone(done_c), .oIdle(idle_c), .oResult(res_c)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Counts edges after the acceptance edge until the selected instance raises oDone.
    task automatic wait_done(input int sel, output int n);
        n = 0;
        while (n < 400) begin
            if (sel == 0 && done_a === 1'b1) break;
            if (sel == 1 && done_b === 1'b1) break;
            if (sel == 2 && done_c === 1'b1) break;
            tick();
            n++;
        end
    endtask

    task automatic start_a(input logic [63:0] d);
        data_a  = d;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
    endtask

    function automatic logic [63:0] model4(input logic [63:0] d);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < 4; i++) p = p * {48'd0, d[i*16 +: 16]};
        return p;
    endfunction

    function automatic logic [63:0] bb_ops(input int r);
        return {16'(r*3 + 7), 16'(r + 300), 16'(r*11 + 2), 16'(1000 + r)};
    endfunction

    initial begin
        int n;
        int acc, prev;
        int zero_lat;
        logic idle_seen;
        logic [63:0] ops;

`ifdef ZERO_SKIP_EN
        zero_lat = 1;
`else
        zero_lat = 51;
`endif
        prev = 0;

        // Reset held for 8 cycles
        repeat (8) tick();
        chk("rst_idle", 128'(idle_a), 128'(1'b1));
        chk("rst_done", 128'(done_a), 128'(1'b0));
        chk("rst_result", 128'(res_a), 128'(64'd0));
        chk("rst_idle_b", 128'(idle_b), 128'(1'b1));
        Reset = 1'b1;
        tick();

        // Basic product 1*2*3*4
        start_a({16'd4, 16'd3, 16'd2, 16'd1});
        chk("basic_idle_falls", 128'(idle_a), 128'(1'b0));
        wait_done(0, n);
        chk("basic_latency", 128'(n), 128'(51));
        chk("basic_result", 128'(res_a), 128'(64'd24));
        chk("basic_idle_while_done", 128'(idle_a), 128'(1'b0));
        repeat (4) tick();
        chk("basic_done_held", 128'(done_a), 128'(1'b1));
        chk("basic_result_held", 128'(res_a), 128'(64'd24));
        ack_a = 1'b1;
        tick();
        ack_a = 1'b0;
        chk("basic_ack_idle", 128'(idle_a), 128'(1'b1));
        chk("basic_ack_done", 128'(done_a), 128'(1'b0));
        chk("basic_result_kept", 128'(res_a), 128'(64'd24));

        // All-ones operands
        start_a({4{16'hFFFF}});
        wait_done(0, n);
        chk("ones_latency", 128'(n), 128'(51));
        chk("ones_result", 128'(res_a), 128'(64'hFFFC_0005_FFFC_0001));
        ack_a = 1'b1;
        tick();
        ack_a = 1'b0;

        // Zero operand
        start_a({16'd9, 16'd7, 16'd5, 16'd0});
        wait_done(0, n);
        chk("zero_latency", 128'(n), 128'(zero_lat));
        chk("zero_result", 128'(res_a), 128'(64'd0));
        ack_a = 1'b1;
        tick();
        ack_a = 1'b0;

        // Handshake abuse: ack held high, valid and data toggled during computation
        ack_a = 1'b1;
        tick();
        chk("abuse_idle_before", 128'(idle_a), 128'(1'b1));
        start_a({16'd11, 16'd7, 16'd5, 16'd3});
        idle_seen = 1'b0;
        n = 0;
        while (done_a !== 1'b1 && n < 400) begin
            if (n < 40) begin
                valid_a = ~valid_a;
                data_a  = {$urandom(), $urandom()};
            end else begin
                valid_a = 1'b0;
            end
            tick();
            n++;
            if (idle_a === 1'b1) idle_seen = 1'b1;
        end
        valid_a = 1'b0;
        chk("abuse_latency", 128'(n), 128'(51));
        chk("abuse_result", 128'(res_a), 128'(64'd1155));
        chk("abuse_no_idle_midway", 128'(idle_seen), 128'(1'b0));
        tick();
        chk("abuse_done_one_cycle", 128'(done_a), 128'(1'b0));
        chk("abuse_back_idle", 128'(idle_a), 128'(1'b1));
        tick();
        chk("abuse_no_restart", 128'(idle_a), 128'(1'b1));
        ack_a = 1'b0;

        // Asynchronous reset in the middle of a calculation
        start_a({16'd4, 16'd3, 16'd2, 16'd1});
        repeat (10) tick();
        chk("midrst_busy", 128'(idle_a), 128'(1'b0));
        #1 Reset = 1'b0;
        #1;
        chk("midrst_idle", 128'(idle_a), 128'(1'b1));
        chk("midrst_done", 128'(done_a), 128'(1'b0));
        chk("midrst_result", 128'(res_a), 128'(64'd0));
        #1 Reset = 1'b1;
        tick();
        chk("midrst_stays_idle", 128'(idle_a), 128'(1'b1));
        chk("midrst_result_clear", 128'(res_a), 128'(64'd0));

        // WIDTH=8, NUM_OPS=2: 200*250
        data_b  = {8'd250, 8'd200};
        valid_b = 1'b1;
        tick();
        valid_b = 1'b0;
        wait_done(1, n);
        chk("w8_latency", 128'(n), 128'(9));
        chk("w8_result", 128'(res_b), 128'(16'd50000));
        ack_b = 1'b1;
        tick();
        ack_b = 1'b0;
        chk("w8_ack_idle", 128'(idle_b), 128'(1'b1));

        // WIDTH=4, NUM_OPS=8: 15^8
        data_c  = {8{4'hF}};
        valid_c = 1'b1;
        tick();
        valid_c = 1'b0;
        wait_done(2, n);
        chk("w4_latency", 128'(n), 128'(35));
        chk("w4_result", 128'(res_c), 128'(32'd2562890625));
        ack_c = 1'b1;
        tick();
        ack_c = 1'b0;

        // Back-to-back with valid and ack tied high
        ack_a   = 1'b1;
        valid_a = 1'b1;
        for (int r = 0; r < 4; r++) begin
            ops    = bb_ops(r);
            data_a = ops;
            n = 0;
            while (idle_a !== 1'b1 && n < 100) begin tick(); n++; end
            n = 0;
            while (idle_a !== 1'b0 && n < 100) begin tick(); n++; end
            acc    = cyc;
            data_a = bb_ops(r + 1);
            if (r > 0) chk("b2b_period", 128'(acc - prev), 128'(53));
            prev = acc;
            wait_done(0, n);
            chk("b2b_latency", 128'(n), 128'(51));
            chk("b2b_result", 128'(res_a), 128'(model4(ops)));
        end
        valid_a = 1'b0;
        tick();
        tick();
        ack_a = 1'b0;
        chk("b2b_final_idle", 128'(idle_a), 128'(1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
